// File: rtl/apb_pkg.sv
// apb_pkg: shared APB state, command/response types and default widths
package apb_pkg;
  localparam int APB_ADDR_W  = 32;
  localparam int APB_DATA_W  = 32;
  localparam int APB_TIMEOUT = 16;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;
  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;
endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: ACCESS wait counter that flags when LIMIT stalled cycles have elapsed
module apb_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  assign expired = cnt == W'(LIMIT);
  // count stalled cycles, saturating at the limit
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/apb_master.sv
// apb_master: valid/ready command stream to APB3 transfers; APB_MASTER_TIMEOUT_EN adds an ACCESS stall abort
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_W,
  parameter int DATA_WIDTH     = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);
  apb_state_e state, state_next;
  logic timeout, done;
`ifdef APB_MASTER_TIMEOUT_EN
  logic expired;
  apb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk    (PCLK),
    .rst    (PRESET),
    .clr    (state == SETUP),
    .inc    (state == ACCESS && !PREADY),
    .expired(expired)
  );
  assign timeout = state == ACCESS && !PREADY && expired;
`else
  assign timeout = 1'b0;
`endif
  assign cmd_ready = state == IDLE;
  assign done      = state == ACCESS && (PREADY || timeout);
  // next-state: IDLE -> SETUP on a command, SETUP -> ACCESS always, ACCESS -> IDLE on completion
  always_comb begin
    state_next = state;
    state_next = state == IDLE   ? (cmd_valid ? SETUP : IDLE) :
                 state == SETUP  ? ACCESS :
                 done            ? IDLE : ACCESS;
  end
  // state, APB pins and response pulse are all registered
  always_ff @(posedge PCLK)
    if (PRESET) begin
      state     <= IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_next;
      PSEL      <= state_next != IDLE;
      PENABLE   <= state_next == ACCESS;
      if (state == IDLE && cmd_valid) begin
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr;
        PWDATA <= cmd_write ? cmd_wdata : '0;
      end
      rsp_valid <= done;
      rsp_rdata <= (state == ACCESS && PREADY && !PWRITE) ? PRDATA : '0;
      rsp_err   <= state == ACCESS && (PREADY ? PSLVERR : timeout);
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed self-checking bench for apb_master
module tb_apb_master;
  logic        PCLK = 1'b0, PRESET = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b1, PSLVERR = 1'b0;
  int checks = 0, errors = 0;
  apb_master dut (
    .PCLK(PCLK), .PRESET(PRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );
  always #5 PCLK = ~PCLK;
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask
  task automatic offer(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask
  task automatic test_reset();
    PRESET = 1'b1;
    tick();
    tick();
    checks++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b exp 000", {PSEL, PENABLE, PWRITE}); end
    checks++; if (PADDR !== 32'h0 || PWDATA !== 32'h0) begin errors++; $display("FAIL reset_bus got %h/%h exp 0/0", PADDR, PWDATA); end
    checks++; if ({rsp_valid, rsp_err} !== 2'b00 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp got %b%b %h exp 00 0", rsp_valid, rsp_err, rsp_rdata); end
    PRESET = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
  endtask
  task automatic test_write_read();
    PREADY = 1'b1;
    checks++; if ({PSEL, PENABLE} !== 2'b00) begin errors++; $display("FAIL wr_idle got %b exp 00", {PSEL, PENABLE}); end
    offer(1'b1, 32'h10, 32'hCAFEF00D);
    tick();
    cmd_valid = 1'b0;
    checks++; if ({PSEL, PENABLE, cmd_ready} !== 3'b100) begin errors++; $display("FAIL wr_setup got %b exp 100", {PSEL, PENABLE, cmd_ready}); end
    checks++; if ({PWRITE, PADDR, PWDATA} !== {1'b1, 32'h10, 32'hCAFEF00D}) begin errors++; $display("FAIL wr_bus got %b %h %h exp 1 10 cafef00d", PWRITE, PADDR, PWDATA); end
    tick();
    checks++; if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin errors++; $display("FAIL wr_access got %b exp 110", {PSEL, PENABLE, rsp_valid}); end
    tick();
    checks++; if ({rsp_valid, rsp_err, PSEL, PENABLE, cmd_ready} !== 5'b10001) begin errors++; $display("FAIL wr_done got %b exp 10001", {rsp_valid, rsp_err, PSEL, PENABLE, cmd_ready}); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata got %h exp 0", rsp_rdata); end
    offer(1'b0, 32'h10, 32'h12345678);
    tick();
    cmd_valid = 1'b0;
    checks++; if ({PWRITE, PADDR, PWDATA} !== {1'b0, 32'h10, 32'h0}) begin errors++; $display("FAIL rd_bus got %b %h %h exp 0 10 0", PWRITE, PADDR, PWDATA); end
    PRDATA = 32'hCAFEF00D;
    tick();
    tick();
    checks++; if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rd_done got %b%b %h exp 10 cafef00d", rsp_valid, rsp_err, rsp_rdata); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_pulse got %b exp 0", rsp_valid); end
  endtask
  task automatic test_wait_states();
    int bad = 0;
    offer(1'b1, 32'h24, 32'hA5A50001);
    PREADY = 1'b0;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b1100 || PADDR !== 32'h24 || PWDATA !== 32'hA5A50001) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ws_hold got %0d bad cycles exp 0", bad); end
    PREADY = 1'b1;
    tick();
    checks++; if ({rsp_valid, cmd_ready, PSEL} !== 3'b110) begin errors++; $display("FAIL ws_done got %b exp 110", {rsp_valid, cmd_ready, PSEL}); end
    checks++; if (PADDR !== 32'h24 || PWDATA !== 32'hA5A50001) begin errors++; $display("FAIL ws_idle_hold got %h %h exp 24 a5a50001", PADDR, PWDATA); end
  endtask
  task automatic test_slave_error();
    offer(1'b0, 32'hFFF0, 32'h0);
    PREADY = 1'b1;
    PSLVERR = 1'b1;
    PRDATA = 32'hDEADBEEF;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    PSLVERR = 1'b0;
    checks++; if ({rsp_valid, rsp_err} !== 2'b11 || rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL err_done got %b%b %h exp 11 deadbeef", rsp_valid, rsp_err, rsp_rdata); end
    tick();
    checks++; if ({rsp_valid, rsp_err} !== 2'b00) begin errors++; $display("FAIL err_pulse got %b exp 00", {rsp_valid, rsp_err}); end
  endtask
  task automatic test_back_to_back();
    int bad = 0;
    PREADY = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i % 3 == 0) begin
        offer(1'b1, 32'h100 + 32'(i / 3) * 4, 32'h5000 + 32'(i));
        if (cmd_ready !== 1'b1) bad++;
      end else if (cmd_ready !== 1'b0) bad++;
      tick();
      if (i % 3 == 0 && ({PSEL, PENABLE} !== 2'b10 || PADDR !== 32'h100 + 32'(i / 3) * 4)) bad++;
      if (i % 3 == 1 && {PSEL, PENABLE, rsp_valid} !== 3'b110) bad++;
      if (i % 3 == 2 && {PSEL, rsp_valid} !== 2'b01) bad++;
    end
    cmd_valid = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_cadence got %0d bad cycles exp 0", bad); end
    tick();
    checks++; if ({PSEL, rsp_valid, cmd_ready} !== 3'b001) begin errors++; $display("FAIL b2b_end got %b exp 001", {PSEL, rsp_valid, cmd_ready}); end
  endtask
  task automatic test_reset_mid();
    offer(1'b0, 32'h44, 32'h0);
    PREADY = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    checks++; if ({PSEL, PENABLE} !== 2'b11) begin errors++; $display("FAIL rm_access got %b exp 11", {PSEL, PENABLE}); end
    PRESET = 1'b1;
    tick();
    checks++; if ({PSEL, PENABLE, rsp_valid} !== 3'b000) begin errors++; $display("FAIL rm_abort got %b exp 000", {PSEL, PENABLE, rsp_valid}); end
    PREADY = 1'b1;
    PRESET = 1'b0;
    tick();
    checks++; if ({PSEL, rsp_valid, cmd_ready} !== 3'b001) begin errors++; $display("FAIL rm_release got %b exp 001", {PSEL, rsp_valid, cmd_ready}); end
  endtask
`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    offer(1'b0, 32'h88, 32'h0);
    PREADY = 1'b0;
    tick();
    cmd_valid = 1'b0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++; if (n != 18 || {rsp_err, PSEL, PENABLE} !== 3'b100) begin errors++; $display("FAIL to_abort got n=%0d %b exp n=18 100", n, {rsp_err, PSEL, PENABLE}); end
    PREADY = 1'b1;
    offer(1'b1, 32'h8C, 32'h1);
    tick();
    cmd_valid = 1'b0;
    checks++; if ({PSEL, PENABLE} !== 2'b10) begin errors++; $display("FAIL to_next got %b exp 10", {PSEL, PENABLE}); end
    tick();
    tick();
  endtask
`endif
  initial begin
    test_reset();
    test_write_read();
    test_wait_states();
    test_slave_error();
    test_back_to_back();
    test_reset_mid();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_master.md
# apb_master

APB3 requester that converts a simple valid/ready command stream into single APB transfers and returns each result as a one-cycle response pulse. It is the initiator end of the bus our `apb` dual-port-memory slave responds on. It replaces the bench's direct pin driving so that RTL and test stimulus both issue transfers through one block. At most one transfer is outstanding; it is sequenced IDLE → SETUP → ACCESS per the APB3 protocol.

## Interface
- ADDR_WIDTH, 32, width of PADDR and cmd_addr
- DATA_WIDTH, 32, width of PWDATA/PRDATA and the command/response data
- TIMEOUT_CYCLES, 16, number of ACCESS cycles with PREADY low before abort (used only with timeout compiled in)

Ports:
- PCLK  in  1  sole clock; all logic on its rising edge
- PRESET  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted this cycle when high together with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  one-cycle pulse: transfer complete
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_err  out  1  PSLVERR of the completing transfer, or a timeout abort
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

## Operation
- FSM states: IDLE, SETUP, ACCESS. Reset state is IDLE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, capture cmd_write, cmd_addr and cmd_wdata into the PWRITE, PADDR and PWDATA registers.
  - PWDATA is forced to 0 for reads.
  - Go to SETUP.
- SETUP: PSEL = 1, PENABLE = 0; unconditionally go to ACCESS.
- ACCESS: PSEL = 1, PENABLE = 1.
  - PREADY = 0: stay in ACCESS.
  - PREADY = 1: register rsp_rdata (PRDATA for reads, 0 for writes) and rsp_err = PSLVERR, pulse rsp_valid, and go to IDLE.
- cmd_ready is 0 in SETUP and ACCESS. Commands offered then are held off, not dropped.
- PADDR, PWRITE and PWDATA stay stable from SETUP through the final ACCESS cycle, and hold their value in IDLE.
- Responses have no backpressure. The consumer must accept rsp_valid in the cycle it is asserted.
- PSLVERR and PRDATA are sampled only in ACCESS with PREADY = 1, and ignored otherwise.

## Timing
- All outputs are registered except cmd_ready, which is decoded from the state register.
- Reset values: PSEL = 0, PENABLE = 0, PWRITE = 0, PADDR = 0, PWDATA = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0; cmd_ready = 1 from the cycle after reset.
- Cycle sequence for command accepted at edge N:
  - SETUP visible after edge N.
  - ACCESS visible after N+1.
  - With PREADY = 1 at N+2, rsp_valid is high after N+2 and the FSM is in IDLE.
  - Minimum transfer period is 3 cycles; each PREADY-low cycle adds 1.
- Back-to-back: a command can be accepted in the same cycle rsp_valid is high, since the FSM is already in IDLE.
- PRESET mid-transfer: at the next edge PSEL and PENABLE drop to 0 and the FSM returns to IDLE; no rsp_valid is issued for the aborted transfer.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A wait counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entry to ACCESS and increments on each ACCESS cycle with PREADY = 0.
  - When it reaches TIMEOUT_CYCLES, the next edge ends the transfer: PSEL = 0, PENABLE = 0, rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, FSM → IDLE.
  - A transfer completing with PREADY = 1 on the same cycle as the limit takes the normal PREADY path.
- APB_MASTER_TIMEOUT_EN undefined: no counter is built, ACCESS waits indefinitely, and TIMEOUT_CYCLES is unused.

## Structure
- Shared package apb_pkg holds:
  - enum apb_state_e {IDLE, SETUP, ACCESS}
  - struct apb_cmd_t {write, addr, wdata}
  - struct apb_rsp_t {rdata, err}
  - default width localparams shared with the `apb` slave
- One sub-module: apb_timeout_cnt (the wait counter), instantiated only under APB_MASTER_TIMEOUT_EN.

## Test plan
- Write then read: write addr 0x10 data 0xCAFEF00D with the slave at zero wait states, then read addr 0x10. Required: PSEL/PENABLE sequence 0/0 → 1/0 → 1/1; each transfer completes in 3 cycles; the read returns rsp_rdata = 0xCAFEF00D with rsp_err = 0.
- Wait states: PREADY held low for 4 ACCESS cycles. Required: PADDR/PWDATA stable throughout; rsp_valid 7 cycles after acceptance; cmd_ready stays 0 until then.
- Slave error: read of an out-of-range address with PSLVERR = 1 and PREADY = 1. Required: rsp_err = 1 for one cycle and rsp_rdata = PRDATA.
- Back-to-back: cmd_valid held high for 3 writes. Required: one acceptance every 3 cycles and no idle gap beyond the IDLE cycle.
- Reset mid-ACCESS: PRESET asserted while PREADY = 0. Required: PSEL = PENABLE = 0 next cycle, no rsp_valid, cmd_ready = 1 after release.
- Timeout (APB_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES = 16): PREADY stuck at 0. Required: rsp_valid with rsp_err = 1 after 16 ACCESS cycles, PSEL dropped, next command accepted.
